// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus bundle: memory-controller request/response plus decoder
// handoff and ROB redirect. master = fetcher side, slave = environment side.
interface inst_fetcher_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_inst;
  logic        if_station_idle;
  logic        if_get_inst;
  logic [31:0] inst_to_dec;
  logic [31:0] pc_to_dec;
  logic        if_jump;
  logic [31:0] jump_pc;

  modport master (
    output mem_req, mem_addr, if_get_inst, inst_to_dec, pc_to_dec,
    input  mem_done, mem_inst, if_station_idle, if_jump, jump_pc
  );

  modport slave (
    input  mem_req, mem_addr, if_get_inst, inst_to_dec, pc_to_dec,
    output mem_done, mem_inst, if_station_idle, if_jump, jump_pc
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetcher: sequential fetch into a circular queue, head to decoder,
// flush/redirect on if_jump. Optional same-cycle bypass under `IQ_BYPASS_EN.
module inst_fetcher #(
  parameter int          IQ_DEPTH = 16,
  parameter int          IQ_PTR_W = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  inst_fetcher_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_entry_t;

  state_t              state, state_nxt;
  logic [31:0]         fetch_pc, pc_nxt, addr_nxt;
  logic                req_nxt, push, pop, byp, full, empty;
  logic [IQ_PTR_W-1:0] head, tail;
  logic [IQ_PTR_W:0]   count;
  iq_entry_t           iq [IQ_DEPTH];

  // IQ_DEPTH is a power of two, so the count MSB alone marks a full queue.
  assign full  = count[IQ_PTR_W];
  assign empty = (count == '0);
  assign pop   = !empty && bus.if_station_idle && !bus.if_jump && rdy_in && !rst_in;

`ifdef IQ_BYPASS_EN
  assign byp = empty && (state == S_WAIT) && bus.mem_done && bus.if_station_idle &&
               !bus.if_jump && rdy_in && !rst_in;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    bus.if_get_inst = pop || byp;
    bus.inst_to_dec = '0;
    bus.pc_to_dec   = '0;
    if (!empty) begin
      bus.inst_to_dec = iq[head].inst;
      bus.pc_to_dec   = iq[head].pc;
    end else if (byp) begin
      bus.inst_to_dec = bus.mem_inst;
      bus.pc_to_dec   = bus.mem_addr;
    end
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= S_IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!bus.if_jump && !full) state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_done)          state_nxt = S_IDLE;
               else if (bus.if_jump)      state_nxt = S_DRAIN;
      S_DRAIN: if (bus.mem_done)          state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: next request, next fetch PC, queue push
  always_comb begin
    req_nxt  = bus.mem_req;
    addr_nxt = bus.mem_addr;
    pc_nxt   = fetch_pc;
    push     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.if_jump) pc_nxt = bus.jump_pc;
        else if (!full) begin
          req_nxt  = 1'b1;
          addr_nxt = fetch_pc;
        end
      end
      S_WAIT: begin
        if (bus.mem_done) begin
          req_nxt = 1'b0;
          if (bus.if_jump) pc_nxt = bus.jump_pc;
          else begin
            pc_nxt = fetch_pc + 32'd4;
            push   = !byp;
          end
        end else if (bus.if_jump) begin
          // Controller still finishes this access; DRAIN swallows its response.
          req_nxt = 1'b0;
          pc_nxt  = bus.jump_pc;
        end
      end
      S_DRAIN: if (bus.if_jump) pc_nxt = bus.jump_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc     <= RESET_PC;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else if (rdy_in) begin
      fetch_pc     <= pc_nxt;
      bus.mem_req  <= req_nxt;
      bus.mem_addr <= addr_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (bus.if_jump) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) iq[tail] <= '{inst: bus.mem_inst, pc: bus.mem_addr};
  end
endmodule

// File: tb/tb_inst_fetcher.sv
// Directed self-checking bench for inst_fetcher; expectations follow the
// build-time choice of `IQ_BYPASS_EN.
module tb_inst_fetcher;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  inst_fetcher_if bus ();

  inst_fetcher #(.IQ_DEPTH(16), .IQ_PTR_W(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    bus.mem_done = 1'b0;
    bus.mem_inst = '0;
    bus.if_station_idle = 1'b0;
    bus.if_jump = 1'b0;
    bus.jump_pc = '0;
    tick();
    rst_in = 1'b0;
  endtask

  // Bounded wait for a request, then check its address.
  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd1);
    chk({tag, "_addr"}, bus.mem_addr, addr);
  endtask

  // Return data two cycles after the request was issued.
  task automatic respond(input logic [31:0] data);
    tick();
    bus.mem_done = 1'b1;
    bus.mem_inst = data;
    tick();
    bus.mem_done = 1'b0;
  endtask

  // Fetch with decoder idle and queue empty: checks when the word reaches the decoder.
  task automatic fetch_pres(input string tag, input logic [31:0] addr, input logic [31:0] data);
    wait_req(tag, addr);
    tick();
    bus.mem_done = 1'b1;
    bus.mem_inst = data;
`ifdef IQ_BYPASS_EN
    #1;
    chk({tag, "_get"}, {31'd0, bus.if_get_inst}, 32'd1);
    chk({tag, "_pc"}, bus.pc_to_dec, addr);
    chk({tag, "_inst"}, bus.inst_to_dec, data);
    tick();
    bus.mem_done = 1'b0;
`else
    tick();
    bus.mem_done = 1'b0;
    #1;
    chk({tag, "_get"}, {31'd0, bus.if_get_inst}, 32'd1);
    chk({tag, "_pc"}, bus.pc_to_dec, addr);
    chk({tag, "_inst"}, bus.inst_to_dec, data);
`endif
  endtask

  initial begin
    // Reset state
    do_reset();
    rst_in = 1'b1;
    bus.if_station_idle = 1'b1;
    bus.if_jump = 1'b1;
    tick();
    chk("rst_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_get",  {31'd0, bus.if_get_inst}, 32'd0);
    chk("rst_inst", bus.inst_to_dec, 32'd0);
    chk("rst_pc",   bus.pc_to_dec, 32'd0);
    bus.if_jump = 1'b0;
    rst_in = 1'b0;

    // Steady fetch, decoder always idle
    for (int n = 0; n < 3; n++) fetch_pres($sformatf("seq%0d", n), n * 4, n * 32'h10);

    // Queue full
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wait_req($sformatf("fill%0d", i), i * 4);
      respond(i * 32'h10 + 32'h1);
    end
    for (int i = 0; i < 4; i++) begin
      chk("full_noreq", {31'd0, bus.mem_req}, 32'd0);
      tick();
    end
    chk("full_noget", {31'd0, bus.if_get_inst}, 32'd0);
    bus.if_station_idle = 1'b1;
    #1;
    chk("full_get",  {31'd0, bus.if_get_inst}, 32'd1);
    chk("full_pc",   bus.pc_to_dec, 32'h0);
    chk("full_inst", bus.inst_to_dec, 32'h1);
    tick();
    bus.if_station_idle = 1'b0;
    chk("full_pc1",    bus.pc_to_dec, 32'h4);
    chk("full_req_lo", {31'd0, bus.mem_req}, 32'd0);
    wait_req("full_next", 32'h40);

    // Flush while a request is outstanding
    do_reset();
    wait_req("fw0", 32'h0); respond(32'h11);
    wait_req("fw1", 32'h4); respond(32'h22);
    wait_req("fw2", 32'h8);
    bus.if_jump = 1'b1;
    bus.jump_pc = 32'h100;
    bus.if_station_idle = 1'b1;
    #1;
    chk("fw_jump_noget", {31'd0, bus.if_get_inst}, 32'd0);
    tick();
    bus.if_jump = 1'b0;
    chk("fw_req_drop", {31'd0, bus.mem_req}, 32'd0);
    chk("fw_empty",    {31'd0, bus.if_get_inst}, 32'd0);
    tick(); tick();
    chk("fw_drain_noreq", {31'd0, bus.mem_req}, 32'd0);
    bus.mem_done = 1'b1;
    bus.mem_inst = 32'hdead_beef;
    tick();
    bus.mem_done = 1'b0;
    chk("fw_discard_get", {31'd0, bus.if_get_inst}, 32'd0);
    chk("fw_discard_pc",  bus.pc_to_dec, 32'd0);
    fetch_pres("fw_new", 32'h100, 32'h33);

    // Flush coinciding with mem_done and a would-be pop
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_req($sformatf("fc%0d", i), i * 4);
      respond(32'h40 + i);
    end
    wait_req("fc3", 32'hC);
    bus.if_station_idle = 1'b1;
    bus.if_jump = 1'b1;
    bus.jump_pc = 32'h200;
    bus.mem_done = 1'b1;
    bus.mem_inst = 32'h4444;
    #1;
    chk("fc_noget", {31'd0, bus.if_get_inst}, 32'd0);
    tick();
    bus.if_jump = 1'b0;
    bus.mem_done = 1'b0;
    chk("fc_empty_get", {31'd0, bus.if_get_inst}, 32'd0);
    chk("fc_empty_pc",  bus.pc_to_dec, 32'd0);
    fetch_pres("fc_new", 32'h200, 32'h55);

    // rdy_in low mid-WAIT
    do_reset();
    wait_req("rd0", 32'h0); respond(32'h66);
    wait_req("rd1", 32'h4);
    bus.if_station_idle = 1'b1;
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rd_noget", {31'd0, bus.if_get_inst}, 32'd0);
      tick();
      chk("rd_req",  {31'd0, bus.mem_req}, 32'd1);
      chk("rd_addr", bus.mem_addr, 32'h4);
    end
    rdy_in = 1'b1;
    #1;
    chk("rd_get", {31'd0, bus.if_get_inst}, 32'd1);
    chk("rd_pc",  bus.pc_to_dec, 32'h0);
    bus.if_station_idle = 1'b0;
    respond(32'h77);
    bus.if_station_idle = 1'b1;
    #1;
    chk("rd_head0", bus.pc_to_dec, 32'h0);
    tick();
    chk("rd_head1_get",  {31'd0, bus.if_get_inst}, 32'd1);
    chk("rd_head1_pc",   bus.pc_to_dec, 32'h4);
    chk("rd_head1_inst", bus.inst_to_dec, 32'h77);

    // Empty-queue presentation timing at a redirected address
    do_reset();
    bus.if_station_idle = 1'b1;
    bus.if_jump = 1'b1;
    bus.jump_pc = 32'h24;
    tick();
    bus.if_jump = 1'b0;
    chk("bp_idle_noreq", {31'd0, bus.mem_req}, 32'd0);
    wait_req("bp", 32'h24);
    tick();
    bus.mem_done = 1'b1;
    bus.mem_inst = 32'h0050_0093;
    #1;
`ifdef IQ_BYPASS_EN
    chk("bp_same_get", {31'd0, bus.if_get_inst}, 32'd1);
    chk("bp_same_pc",  bus.pc_to_dec, 32'h24);
    chk("bp_same_inst", bus.inst_to_dec, 32'h0050_0093);
`else
    chk("bp_same_get", {31'd0, bus.if_get_inst}, 32'd0);
`endif
    tick();
    bus.mem_done = 1'b0;
`ifdef IQ_BYPASS_EN
    chk("bp_next_get", {31'd0, bus.if_get_inst}, 32'd0);
`else
    chk("bp_next_get",  {31'd0, bus.if_get_inst}, 32'd1);
    chk("bp_next_pc",   bus.pc_to_dec, 32'h24);
    chk("bp_next_inst", bus.inst_to_dec, 32'h0050_0093);
`endif
    wait_req("bp_after", 32'h28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the decoder.
- Generates sequential fetch addresses and requests one 32-bit instruction at a time from the memory controller.
- Buffers returned instructions with their PCs in a circular instruction queue, and hands the queue head to the decoder when all stations report idle.
- Redirects to the ROB-supplied target on a jump/mispredict flush, discarding queued and in-flight instructions.

Parameters:
IQ_DEPTH, 16, instruction queue entries (power of 2, >=2)
IQ_PTR_W, 4, log2(IQ_DEPTH)
RESET_PC, 32'h0, fetch address after reset

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, synchronous, active-high
rdy_in  input  1  global enable; low = freeze all state
mem_req  output  1  fetch request, registered
mem_addr  output  32  fetch address, registered
mem_done  input  1  one-cycle pulse, mem_inst valid
mem_inst  input  32  fetched instruction word
if_station_idle  input  1  decoder reports ROB/RS/LSB all have space
if_get_inst  output  1  head valid and transferred this cycle
inst_to_dec  output  32  instruction at queue head
pc_to_dec  output  32  PC of that instruction
if_jump  input  1  flush/redirect from ROB commit
jump_pc  input  32  redirect target

Behaviour:
- Interface: one clock, clk_in; reset is synchronous and active-high, rst_in.
- Reset, on a clk_in edge with rst_in=1:
  - state=IDLE, fetch_pc=RESET_PC, head=tail=count=0.
  - mem_req=0, mem_addr=0.
  - if_get_inst=0; inst_to_dec and pc_to_dec are 0.
  - rst_in overrides rdy_in and if_jump.
- rdy_in=0: no register changes; if_get_inst forced 0; mem_req/mem_addr hold.
- Decoder handshake:
  - if_get_inst = count!=0 && if_station_idle && !if_jump && rdy_in && !rst_in (combinational).
  - inst_to_dec/pc_to_dec = head entry (combinational); driven 0 when count==0.
  - On the edge where if_get_inst=1, head advances (mod IQ_DEPTH) and count decrements.
- States:
  - IDLE:
    - if_jump: fetch_pc<=jump_pc, stay IDLE.
    - else if count<IQ_DEPTH: mem_req<=1, mem_addr<=fetch_pc, go WAIT.
    - else stay IDLE (queue full, no request).
  - WAIT: mem_req/mem_addr held until mem_done.
    - mem_done && !if_jump: push {mem_inst, mem_addr} at tail, fetch_pc<=fetch_pc+4, mem_req<=0, go IDLE.
    - mem_done && if_jump: response discarded, fetch_pc<=jump_pc, mem_req<=0, go IDLE.
    - !mem_done && if_jump: mem_req<=0, fetch_pc<=jump_pc, go DRAIN. The controller completes a started transaction regardless of mem_req.
  - DRAIN: wait for mem_done, discard the data, go IDLE. A further if_jump here updates fetch_pc only.
- Throughput: one instruction per IDLE+WAIT sequence, with at least one IDLE cycle between requests.
- Flush (if_jump=1): head=tail=count=0 on that edge and no pop that cycle. A push in the same cycle is suppressed.
- Simultaneous push and pop: count unchanged. A push is only possible if count<IQ_DEPTH at request time, and count cannot grow while in WAIT, so no overflow.
- Arithmetic: fetch_pc+4 wraps modulo 2^32; pointers wrap modulo IQ_DEPTH.

Optional Feature:
IQ_BYPASS_EN
- Defined: when count==0, state WAIT, mem_done=1, if_station_idle=1, !if_jump and rdy_in, then:
  - if_get_inst=1, inst_to_dec=mem_inst, pc_to_dec=mem_addr in the same cycle.
  - The word is not pushed; fetch_pc still advances by 4.
- Undefined: every returned word is pushed; earliest decoder presentation is the cycle after mem_done.

Test Plan:
- Reset then steady fetch: rst_in 1 cycle, memory returns word N*0x10 after 2 cycles, if_station_idle=1 -> mem_addr sequence 0x0,0x4,0x8; pc_to_dec 0x0,0x4,0x8 with matching inst_to_dec; no PC skipped or repeated.
- Queue full: if_station_idle=0 with IQ_DEPTH=16 -> exactly 16 requests (last mem_addr=0x3C), then mem_req stays 0. Raise if_station_idle for 1 cycle -> pc 0x0 popped and the next request goes to 0x40.
- Flush during WAIT: request 0x8 outstanding; pulse if_jump with jump_pc=0x100 -> DRAIN; a late mem_done for 0x8 is discarded, count=0, next mem_addr=0x100.
- Flush coincident with mem_done and pop: count=3, if_jump=1, mem_done=1 -> count=0, no if_get_inst, next request 0x200 when jump_pc=0x200.
- rdy_in low for 5 cycles mid-WAIT with mem_done absent -> state, count and mem_addr unchanged; if_get_inst=0 throughout.
- IQ_BYPASS_EN defined, queue empty, mem_done with mem_inst=0x00500093 at 0x24 -> same cycle if_get_inst=1, pc_to_dec=0x24, count stays 0. Undefined -> presented the following cycle.
